// File: rtl/odo_pkg.sv
// Shared widths, lane geometry and FSM encoding for the Odo S-box word sequencer.
package odo_pkg;

  localparam int ODO_WORD_W = 64;
  localparam int SMALL_W    = 6;
  localparam int LARGE_W    = 10;
  localparam int LANES      = 4;
  localparam int LANE_W     = SMALL_W + LARGE_W;
  localparam int LANE_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } odo_seq_state_e;

  typedef struct packed {
    logic                  vld;
    logic [LANE_IDX_W-1:0] lane;
  } ret_tag_t;

  // Bit offset of the small-lane field of lane k; the large field follows it.
  function automatic int lane_lsb(input int k);
    return LANE_W * k;
  endfunction

endpackage

// File: rtl/odo_sbox_ret_tag.sv
// Shift pipe that tags each S-box issue with {valid, lane} so the returning
// ROM data can be steered into the right lane after DEPTH cycles.
module odo_sbox_ret_tag
  import odo_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_vld,
  input  logic [LANE_IDX_W-1:0] issue_lane,
  output ret_tag_t              ret
);

  ret_tag_t pipe [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{vld: issue_vld, lane: issue_lane};
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign ret = pipe[DEPTH-1];

endmodule

// File: rtl/odo_sbox_word_sequencer.sv
// Time-shares one small/large S-box ROM pair across a 64-bit Odo word:
// issues four lane pairs, collects tagged returns, presents the substituted word.
module odo_sbox_word_sequencer
  import odo_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ODO_WORD_W-1:0] word_in,
  output logic [SMALL_W-1:0]    small_in,
  input  logic [SMALL_W-1:0]    small_out,
  output logic [LARGE_W-1:0]    large_in,
  input  logic [LARGE_W-1:0]    large_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ODO_WORD_W-1:0] word_out
);

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

  odo_seq_state_e        state, state_nxt;
  logic [ODO_WORD_W-1:0] word_q;
  logic [ODO_WORD_W-1:0] result_q;
  logic [LANE_IDX_W-1:0] cnt_q;
  logic [SMALL_W-1:0]    small_hold;
  logic [LARGE_W-1:0]    large_hold;
  logic [SMALL_W-1:0]    small_sel;
  logic [LARGE_W-1:0]    large_sel;
  logic                  accept;
  logic                  issue;
  ret_tag_t              ret;

  assign accept    = (state == IDLE) && in_valid;
  assign issue     = (state == ISSUE);
  assign small_sel = word_q[lane_lsb(int'(cnt_q)) +: SMALL_W];
  assign large_sel = word_q[lane_lsb(int'(cnt_q)) + SMALL_W +: LARGE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)                             state_nxt = ISSUE;
      ISSUE:   if (cnt_q == LAST_LANE)                   state_nxt = DRAIN;
      DRAIN:   if (ret.vld && (ret.lane == LAST_LANE))   state_nxt = DONE;
      DONE:    if (out_ready)                            state_nxt = IDLE;
      default:                                           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    small_in  = small_hold;
    large_in  = large_hold;
    if (issue) begin
      small_in = small_sel;
      large_in = large_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      word_q <= word_in;
      cnt_q  <= '0;
    end else if (issue) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Address bus keeps the last issued lane so the ROM inputs stay quiet between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      small_hold <= '0;
      large_hold <= '0;
    end else if (issue) begin
      small_hold <= small_sel;
      large_hold <= large_sel;
    end
  end

  odo_sbox_ret_tag #(
    .DEPTH (SBOX_LAT)
  ) u_ret_tag (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_vld  (issue),
    .issue_lane (cnt_q),
    .ret        (ret)
  );

  // Untagged ROM data (idle cycles, returns of a word aborted by reset) never lands here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else if (ret.vld) begin
      result_q[lane_lsb(int'(ret.lane)) +: SMALL_W]           <= small_out;
      result_q[lane_lsb(int'(ret.lane)) + SMALL_W +: LARGE_W] <= large_out;
    end
  end

  assign word_out = result_q;

endmodule

// File: tb/tb_odo_sbox_word_sequencer.sv
// Directed bench for odo_sbox_word_sequencer with 1-cycle and 3-cycle ROM models.
module tb_odo_sbox_word_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
  logic [63:0] word_in1 = '0, word_out1;
  logic [5:0]  small_in1, small_out1 = '0;
  logic [9:0]  large_in1, large_out1 = '0;

  logic        in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b1;
  logic [63:0] word_in3 = '0, word_out3;
  logic [5:0]  small_in3, small_out3 = '0;
  logic [9:0]  large_in3, large_out3 = '0;

  int total = 0;
  int bad = 0;

  function automatic logic [5:0] sm(input logic [5:0] a);
    case (a)
      6'h00:   return 6'h25;
      6'h01:   return 6'h39;
      6'h2b:   return 6'h00;
      6'h3f:   return 6'h11;
      default: return 6'((a * 6'd7) + 6'd3);
    endcase
  endfunction

  function automatic logic [9:0] lg(input logic [9:0] a);
    logic [9:0] p;
    p = 10'(a * 10'd421);
    return p ^ 10'h2c5;
  endfunction

  function automatic logic [63:0] exp_word(input logic [63:0] w);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[16*k +: 6]     = sm(w[16*k +: 6]);
      r[16*k + 6 +: 10] = lg(w[16*k + 6 +: 10]);
    end
    return r;
  endfunction

  // Registered ROM models: 1 stage and 3 stages
  always @(posedge clk) begin
    small_out1 <= sm(small_in1);
    large_out1 <= lg(large_in1);
  end

  logic [5:0] sa0, sa1;
  logic [9:0] la0, la1;
  always @(posedge clk) begin
    sa0 <= small_in3;
    sa1 <= sa0;
    small_out3 <= sm(sa1);
    la0 <= large_in3;
    la1 <= la0;
    large_out3 <= lg(la1);
  end

  odo_sbox_word_sequencer #(.SBOX_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .word_in(word_in1), .small_in(small_in1), .small_out(small_out1),
    .large_in(large_in1), .large_out(large_out1), .out_valid(out_valid1),
    .out_ready(out_ready1), .word_out(word_out1)
  );

  odo_sbox_word_sequencer #(.SBOX_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .word_in(word_in3), .small_in(small_in3), .small_out(small_out3),
    .large_in(large_in3), .large_out(large_out3), .out_valid(out_valid3),
    .out_ready(out_ready3), .word_out(word_out3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Offers a word, waits for accept, then counts cycles until out_valid (cycle after accept = 1).
  task automatic xfer(input bit use3, input logic [63:0] w, output logic [63:0] res, output int lat);
    int n;
    bit rdy;
    @(negedge clk);
    if (use3) begin in_valid3 = 1'b1; word_in3 = w; end
    else      begin in_valid1 = 1'b1; word_in1 = w; end
    n = 0;
    rdy = use3 ? in_ready3 : in_ready1;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
      rdy = use3 ? in_ready3 : in_ready1;
    end
    @(posedge clk); #1;
    if (use3) in_valid3 = 1'b0; else in_valid1 = 1'b0;
    lat = 1;
    while (!(use3 ? out_valid3 : out_valid1) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = use3 ? word_out3 : word_out1;
  endtask

  typedef struct {
    logic [63:0] word;
    logic [63:0] exp;
  } vec_t;

  initial begin
    vec_t        vt [4];
    logic [63:0] res, held, wa, wb;
    logic [63:0] bw [3];
    int          lat;
    int          acc_cyc [$];
    logic [63:0] got [$];
    int          wi;

    vt[0] = '{64'h0, 64'hB165_B165_B165_B165};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h2791_2791_2791_2791};
    vt[2] = '{64'hAAAB_5541_FFC0_007F, exp_word(64'hAAAB_5541_FFC0_007F)};
    vt[3] = '{64'h0123_4567_89AB_CDEF, exp_word(64'h0123_4567_89AB_CDEF)};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready1), 64'd1);
    chk("rst_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_word_out", word_out1, 64'd0);
    chk("rst_small_in", 64'(small_in1), 64'd0);
    chk("rst_large_in", 64'(large_in1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, vt[i].word, res, lat);
      chk("vec_word", res, vt[i].exp);
      chk("vec_lat", 64'(lat), 64'd6);
      @(posedge clk); #1;
    end

    // Lane order and small-lane substitutions of the mixed word
    xfer(1'b0, 64'hAAAB_5541_FFC0_007F, res, lat);
    chk("small_l0", 64'(res[5:0]), 64'h11);
    chk("small_l1", 64'(res[21:16]), 64'h25);
    chk("small_l2", 64'(res[37:32]), 64'h39);
    chk("small_l3", 64'(res[53:48]), 64'h00);
    @(posedge clk); #1;

    // Back-pressure in DONE
    out_ready1 = 1'b0;
    xfer(1'b0, 64'h1357_9BDF_2468_ACE0, res, lat);
    held = res;
    chk("bp_word", res, exp_word(64'h1357_9BDF_2468_ACE0));
    in_valid1 = 1'b1;
    word_in1 = 64'hDEAD_BEEF_0000_1111;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(out_valid1), 64'd1);
      chk("bp_word_hold", word_out1, held);
      chk("bp_in_ready", 64'(in_ready1), 64'd0);
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(out_valid1), 64'd0);
    chk("bp_release_ready", 64'(in_ready1), 64'd1);

    // Back-to-back words with out_ready high
    bw[0] = 64'h0F0F_F0F0_3C3C_C3C3;
    bw[1] = 64'h8000_0001_7FFF_FFFE;
    bw[2] = 64'h5A5A_A5A5_6996_9669;
    wi = 0;
    @(negedge clk);
    in_valid1 = 1'b1;
    word_in1 = bw[0];
    for (int c = 0; c < 30; c++) begin
      bit acc;
      if (c > 0) @(negedge clk);
      if (out_valid1) got.push_back(word_out1);
      acc = in_ready1 && in_valid1;
      if (acc) acc_cyc.push_back(c);
      @(posedge clk); #1;
      if (acc) begin
        wi++;
        if (wi < 3) word_in1 = bw[wi];
        else        in_valid1 = 1'b0;
      end
    end
    in_valid1 = 1'b0;
    chk("b2b_accepts", 64'(acc_cyc.size()), 64'd3);
    chk("b2b_outputs", 64'(got.size()), 64'd3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap0", 64'(acc_cyc[1] - acc_cyc[0]), 64'd7);
      chk("b2b_gap1", 64'(acc_cyc[2] - acc_cyc[1]), 64'd7);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) chk("b2b_word", got[i], exp_word(bw[i]));
    end

    // Reset during DRAIN
    wa = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    in_valid1 = 1'b1;
    word_in1 = wa;
    begin
      int n;
      n = 0;
      while (!in_ready1 && n < 50) begin @(negedge clk); n++; end
    end
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 64'(in_ready1), 64'd1);
    chk("rst_mid_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_mid_word_out", word_out1, 64'd0);
    chk("rst_mid_small_in", 64'(small_in1), 64'd0);
    chk("rst_mid_large_in", 64'(large_in1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wb = 64'h0040_0001_8002_C003;
    xfer(1'b0, wb, res, lat);
    chk("post_rst_word", res, exp_word(wb));
    chk("post_rst_lat", 64'(lat), 64'd6);
    @(posedge clk); #1;

    // SBOX_LAT=3 instance
    xfer(1'b1, 64'h0, res, lat);
    chk("lat3_word0", res, 64'hB165_B165_B165_B165);
    chk("lat3_lat0", 64'(lat), 64'd8);
    @(posedge clk); #1;
    xfer(1'b1, 64'hAAAB_5541_FFC0_007F, res, lat);
    chk("lat3_word1", res, exp_word(64'hAAAB_5541_FFC0_007F));
    chk("lat3_lat1", 64'(lat), 64'd8);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
